// File: rtl/bpu_btb_pkg.sv
// Shared types, defaults and PC slicing helpers for the branch prediction unit.
package bpu_btb_pkg;

    localparam int BPU_XLEN    = 32;
    localparam int BPU_TAG_W   = 8;
    localparam int BPU_CNT_W   = 2;

    localparam int BPU_STATIC  = 0;
    localparam int BPU_DYNAMIC = 1;

    typedef struct packed {
        logic                 valid;
        logic [BPU_TAG_W-1:0] tag;
        logic [BPU_XLEN-1:0]  target;
        logic [BPU_CNT_W-1:0] cnt;
    } bpu_entry_t;

    // pc[1:0] never participates; index sits directly above them, tag above the index.
    function automatic logic [63:0] bpu_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] bpu_tag(input logic [63:0] pc, input int idx_w, input int tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bpu_btb_sat_counter.sv
// Saturating up/down next-value logic; purely combinational, the caller owns the register.
// Up and down together (or neither) hold the value.
module bpu_btb_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] i_val,
    input  logic         i_up,
    input  logic         i_dn,
    output logic [W-1:0] o_next
);

    always_comb begin
        o_next = i_val;
        if (i_up && !i_dn && (i_val != '1)) begin
            o_next = i_val + W'(1);
        end else if (i_dn && !i_up && (i_val != '0)) begin
            o_next = i_val - W'(1);
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters and resolve/mispredict stats.
// Lookup is combinational against pre-update contents; one update per cycle, no backpressure.
module bpu_btb
    import bpu_btb_pkg::*;
#(
    parameter int XLEN    = BPU_XLEN,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = BPU_TAG_W,
    parameter int CNT_W   = BPU_CNT_W,
    parameter int MODE    = BPU_DYNAMIC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispred,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t [ENTRIES-1:0] r_tab;
    logic [31:0]          r_branch_cnt;
    logic [31:0]          r_mispred_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic [TAG_W-1:0] w_u_tag;
    entry_t           w_f_ent;
    entry_t           w_u_ent;
    logic             w_f_hit;
    logic             w_u_hit;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      w_branch_next;
    logic [31:0]      w_mispred_next;

    assign w_f_idx = IDX_W'(bpu_index(64'(pc_f), IDX_W));
    assign w_u_idx = IDX_W'(bpu_index(64'(upd_pc), IDX_W));
    assign w_f_tag = TAG_W'(bpu_tag(64'(pc_f), IDX_W, TAG_W));
    assign w_u_tag = TAG_W'(bpu_tag(64'(upd_pc), IDX_W, TAG_W));
    assign w_f_ent = r_tab[w_f_idx];
    assign w_u_ent = r_tab[w_u_idx];
    assign w_f_hit = w_f_ent.valid && (w_f_ent.tag == w_f_tag);
    assign w_u_hit = w_u_ent.valid && (w_u_ent.tag == w_u_tag);

    // Gating on rst keeps the front end at pc+4 while the table is being cleared.
    assign pred_taken  = (MODE == BPU_DYNAMIC) && !rst && w_f_hit && w_f_ent.cnt[CNT_W-1];
    assign pred_target = pred_taken ? w_f_ent.target : pc_f + XLEN'(4);

    bpu_btb_sat_counter #(.W(CNT_W)) u_dir_cnt (
        .i_val  (w_u_ent.cnt),
        .i_up   (upd_taken),
        .i_dn   (!upd_taken),
        .o_next (w_cnt_next)
    );

    bpu_btb_sat_counter #(.W(32)) u_branch_cnt (
        .i_val  (r_branch_cnt),
        .i_up   (upd_valid),
        .i_dn   (1'b0),
        .o_next (w_branch_next)
    );

    bpu_btb_sat_counter #(.W(32)) u_mispred_cnt (
        .i_val  (r_mispred_cnt),
        .i_up   (upd_valid && upd_mispred),
        .i_dn   (1'b0),
        .o_next (w_mispred_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tab[i].valid <= 1'b0;
                r_tab[i].cnt   <= '0;
            end
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_branch_cnt  <= w_branch_next;
            r_mispred_cnt <= w_mispred_next;
            // A taken miss reallocates the slot; not-taken never allocates.
            if (upd_valid && upd_taken) begin
                r_tab[w_u_idx].valid  <= 1'b1;
                r_tab[w_u_idx].tag    <= w_u_tag;
                r_tab[w_u_idx].target <= upd_target;
                r_tab[w_u_idx].cnt    <= w_u_hit ? w_cnt_next : CNT_WEAK;
            end else if (upd_valid && w_u_hit) begin
                r_tab[w_u_idx].cnt <= w_cnt_next;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_bpu_btb.sv
// Bench for bpu_btb: directed scenarios plus randomized traffic against a table-level model.
module tb_bpu_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;

    logic        pred_taken,   s_pred_taken;
    logic [31:0] pred_target,  s_pred_target;
    logic [31:0] branch_cnt,   s_branch_cnt;
    logic [31:0] mispred_cnt,  s_mispred_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: one slot per index, counters as plain integers.
    bit          m_valid [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    longint      m_bc, m_mc;

    always #5 clk = ~clk;

    bpu_btb #(.MODE(1)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispred(upd_mispred),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    bpu_btb #(.MODE(0)) dut_s (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispred(upd_mispred),
        .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int m_tagf(input logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagf(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        logic [31:0] nxt;
        nxt = pc + 32'd4;
        return m_taken(pc) ? m_tgt[m_idx(pc)] : nxt;
    endfunction

    // Apply the pending inputs to the model, then advance one clock.
    task automatic tick();
        int i;
        i = m_idx(upd_pc);
        if (rst) begin
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 1'b0;
                m_cnt[k]   = 0;
            end
            m_bc = 0;
            m_mc = 0;
        end else if (upd_valid) begin
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (upd_mispred && m_mc < 64'hFFFF_FFFF) m_mc++;
            if (upd_taken) begin
                if (m_hit(upd_pc)) begin
                    if (m_cnt[i] < 3) m_cnt[i]++;
                end else begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = m_tagf(upd_pc);
                    m_cnt[i]   = 2;
                end
                m_tgt[i] = upd_target;
            end else if (m_hit(upd_pc) && m_cnt[i] > 0) begin
                m_cnt[i]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input bit v, input logic [31:0] pc, input bit t,
                           input logic [31:0] tg, input bit mp);
        upd_valid   = v;
        upd_pc      = pc;
        upd_taken   = t;
        upd_target  = tg;
        upd_mispred = mp;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_upd(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        pc_f = 32'h100;
        set_upd(0, 0, 0, 0, 0);
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL reset_during: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL reset_cold_lookup: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
        total++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_stats: branch=%0d mispred=%0d want 0/0", branch_cnt, mispred_cnt);
        end
        pc_f = 32'hFFFF_FFFC;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            bad++;
            $display("FAIL reset_wrap: taken=%0b target=%h want 0/00000000", pred_taken, pred_target);
        end
    endtask

    task automatic test_allocate();
        // Table is empty here: same-cycle lookup must not see the update.
        set_upd(1, 32'h100, 1, 32'h200, 0);
        pc_f = 32'h100;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL collision_same_cycle: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
        tick();
        set_upd(0, 0, 0, 0, 0);
        #1;
        total++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            bad++;
            $display("FAIL alloc_hit: taken=%0b target=%h want 1/00000200", pred_taken, pred_target);
        end
        for (int k = 0; k < 2; k++) begin
            set_upd(1, 32'h100, 1, 32'h200, 0);
            tick();
        end
        set_upd(1, 32'h100, 0, 32'h0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0);
        #1;
        total++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            bad++;
            $display("FAIL saturate_top: taken=%0b target=%h want 1/00000200", pred_taken, pred_target);
        end
        set_upd(1, 32'h100, 0, 32'h0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0);
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL saturate_down: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
    endtask

    task automatic test_train_down();
        do_reset();
        set_upd(1, 32'h100, 1, 32'h200, 0);
        tick();
        set_upd(1, 32'h100, 0, 32'h0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0);
        pc_f = 32'h100;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL train_down_weak: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
        for (int k = 0; k < 2; k++) begin
            set_upd(1, 32'h100, 0, 32'h0, 0);
            tick();
        end
        // From a floored counter one taken update must still predict not-taken.
        set_upd(1, 32'h100, 1, 32'h280, 0);
        tick();
        set_upd(0, 0, 0, 0, 0);
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL saturate_floor: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
        set_upd(1, 32'h100, 1, 32'h280, 0);
        tick();
        set_upd(1, 32'h300, 0, 32'h0, 0);
        tick();
        set_upd(0, 0, 0, 0, 0);
        pc_f = 32'h300;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin
            bad++;
            $display("FAIL nt_no_alloc: taken=%0b target=%h want 0/00000304", pred_taken, pred_target);
        end
        pc_f = 32'h100;
        #1;
        total++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h280) begin
            bad++;
            $display("FAIL nt_miss_untouched: taken=%0b target=%h want 1/00000280", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        do_reset();
        set_upd(1, 32'h100, 1, 32'h200, 0);
        tick();
        set_upd(0, 0, 0, 0, 0);
        pc_f = 32'h500;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h504) begin
            bad++;
            $display("FAIL alias_tag_miss: taken=%0b target=%h want 0/00000504", pred_taken, pred_target);
        end
        set_upd(1, 32'h500, 1, 32'h900, 0);
        tick();
        set_upd(0, 0, 0, 0, 0);
        pc_f = 32'h100;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL alias_evicted: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
        pc_f = 32'h502;
        #1;
        total++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h900) begin
            bad++;
            $display("FAIL alias_replaced: taken=%0b target=%h want 1/00000900", pred_taken, pred_target);
        end
    endtask

    task automatic test_stats();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_upd(1, 32'h1000 + 32'(k * 16), k[0], 32'h40 + 32'(k * 8), (k == 1) || (k == 3));
            tick();
            set_upd(0, 32'h1000, 1, 32'h0, 1);
            tick();
        end
        total++;
        if (branch_cnt !== 32'd5 || mispred_cnt !== 32'd2) begin
            bad++;
            $display("FAIL stats_count: branch=%0d mispred=%0d want 5/2", branch_cnt, mispred_cnt);
        end
        set_upd(1, 32'h100, 1, 32'h200, 1);
        tick();
        rst  = 1'b1;
        pc_f = 32'h100;
        #1;
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL reset_masks_hit: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
        tick();
        rst = 1'b0;
        set_upd(0, 0, 0, 0, 0);
        #1;
        total++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_priority_stats: branch=%0d mispred=%0d want 0/0", branch_cnt, mispred_cnt);
        end
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            bad++;
            $display("FAIL reset_priority_table: taken=%0b target=%h want 0/00000104", pred_taken, pred_target);
        end
    endtask

    task automatic test_static();
        do_reset();
        set_upd(1, 32'h100, 1, 32'h200, 1);
        tick();
        set_upd(0, 0, 0, 0, 0);
        pc_f = 32'h100;
        #1;
        total++;
        if (pred_taken !== 1'b1 || s_pred_taken !== 1'b0 || s_pred_target !== 32'h104) begin
            bad++;
            $display("FAIL static_mode: dyn=%0b static=%0b/%h want 1 and 0/00000104",
                     pred_taken, s_pred_taken, s_pred_target);
        end
        total++;
        if (s_branch_cnt !== 32'd1 || s_mispred_cnt !== 32'd1) begin
            bad++;
            $display("FAIL static_stats: branch=%0d mispred=%0d want 1/1", s_branch_cnt, s_mispred_cnt);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        case ($urandom_range(0, 6))
            0: base = 32'h100;
            1: base = 32'h500;
            2: base = 32'h4100;
            3: base = 32'h108;
            4: base = 32'h1108;
            5: base = 32'hFFFF_FFFC;
            default: base = $urandom;
        endcase
        return base | 32'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic        exp_t;
        logic [31:0] exp_tg;
        logic [31:0] nxt;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 127) == 0);
            set_upd($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 2) != 0,
                    $urandom, $urandom_range(0, 3) == 0);
            pc_f = rand_pc();
            #1;
            nxt    = pc_f + 32'd4;
            exp_t  = rst ? 1'b0 : m_taken(pc_f);
            exp_tg = rst ? nxt : m_target(pc_f);
            total++;
            if (pred_taken !== exp_t || pred_target !== exp_tg) begin
                bad++;
                $display("FAIL rand_pred[%0d]: pc=%h taken=%0b target=%h want %0b/%h",
                         n, pc_f, pred_taken, pred_target, exp_t, exp_tg);
            end
            total++;
            if (s_pred_taken !== 1'b0 || s_pred_target !== nxt) begin
                bad++;
                $display("FAIL rand_static[%0d]: pc=%h taken=%0b target=%h want 0/%h",
                         n, pc_f, s_pred_taken, s_pred_target, nxt);
            end
            total++;
            if (branch_cnt !== 32'(m_bc) || mispred_cnt !== 32'(m_mc) ||
                s_branch_cnt !== 32'(m_bc) || s_mispred_cnt !== 32'(m_mc)) begin
                bad++;
                $display("FAIL rand_stats[%0d]: dyn=%0d/%0d static=%0d/%0d want %0d/%0d",
                         n, branch_cnt, mispred_cnt, s_branch_cnt, s_mispred_cnt, m_bc, m_mc);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        pc_f = 32'h0;
        set_upd(0, 0, 0, 0, 0);
        m_bc = 0;
        m_mc = 0;
        for (int k = 0; k < 64; k++) begin
            m_valid[k] = 1'b0;
            m_tag[k]   = 0;
            m_tgt[k]   = 32'h0;
            m_cnt[k]   = 0;
        end
        test_reset();
        test_allocate();
        test_train_down();
        test_alias();
        test_stats();
        test_static();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
